spi_config_ctrl: RTL and testbench

SPI_CONFIG_CTRL -- requirements
Module: spi_config_ctrl

---
 rtl/spi_config_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_config_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_config_ctrl.sv
// Double-buffered configuration block: SPI writes land in shadow registers and a
// commit copies them to the active outputs at the next T2-frame boundary, or when the timeout expires.
module spi_config_ctrl #(
    parameter logic [15:0] APPLY_TIMEOUT = 16'hFFFF,
    parameter logic [7:0]  CTRL_ADDR     = 8'h08,
    parameter logic [7:0]  COMMIT_ADDR   = 8'h0F
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  SPI_DATA,
    input  logic [7:0]  SPI_ADDRESS,
    input  logic        SPI_ENA,
    input  logic        FRAME_START,
    output logic [7:0]  PLP_ID,
    output logic [15:0] T2_ID,
    output logic [31:0] BITRATE,
    output logic        ENABLE,
    output logic        PCR_INSERT,
    output logic        CFG_UPDATE,
    output logic        PENDING,
    output logic        TIMEOUT_FLAG,
    output logic        BAD_ADDR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] cnt;

    logic [7:0]  sh_plp;
    logic [15:0] sh_t2;
    logic [31:0] sh_bitrate;
    logic [1:0]  sh_ctrl;

    logic        is_data;
    logic        is_commit;
    logic        wr_bad;

    always_comb begin
        is_data   = ((SPI_ADDRESS >= 8'h01) && (SPI_ADDRESS <= 8'h07)) || (SPI_ADDRESS == CTRL_ADDR);
        is_commit = SPI_ENA && (SPI_ADDRESS == COMMIT_ADDR);
        wr_bad    = SPI_ENA && !is_data && (SPI_ADDRESS != COMMIT_ADDR);
    end

    // Shadow bank accepts writes in every state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_plp     <= '0;
            sh_t2      <= '0;
            sh_bitrate <= '0;
            sh_ctrl    <= '0;
        end else if (SPI_ENA && is_data) begin
            if (SPI_ADDRESS == CTRL_ADDR) begin
                sh_ctrl <= SPI_DATA[1:0];
            end else begin
                case (SPI_ADDRESS)
                    8'h01:   sh_plp            <= SPI_DATA;
                    8'h02:   sh_t2[7:0]        <= SPI_DATA;
                    8'h03:   sh_t2[15:8]       <= SPI_DATA;
                    8'h04:   sh_bitrate[7:0]   <= SPI_DATA;
                    8'h05:   sh_bitrate[15:8]  <= SPI_DATA;
                    8'h06:   sh_bitrate[23:16] <= SPI_DATA;
                    8'h07:   sh_bitrate[31:24] <= SPI_DATA;
                    default: sh_plp            <= sh_plp;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            PLP_ID       <= '0;
            T2_ID        <= '0;
            BITRATE      <= '0;
            ENABLE       <= 1'b0;
            PCR_INSERT   <= 1'b0;
            CFG_UPDATE   <= 1'b0;
            PENDING      <= 1'b0;
            TIMEOUT_FLAG <= 1'b0;
            BAD_ADDR     <= 1'b0;
        end else begin
            CFG_UPDATE <= 1'b0;
            if (wr_bad) begin
                BAD_ADDR <= 1'b1;
            end
            case (state)
                IDLE, APPLY: begin
                    if (is_commit) begin
                        state        <= PEND;
                        PENDING      <= 1'b1;
                        cnt          <= APPLY_TIMEOUT;
                        BAD_ADDR     <= 1'b0;
                        TIMEOUT_FLAG <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        PENDING <= 1'b0;
                    end
                end
                PEND: begin
                    // Frame boundary wins over an expiring counter; commits here are dropped.
                    if (FRAME_START || (cnt == 16'd0)) begin
                        state      <= APPLY;
                        PENDING    <= 1'b0;
                        CFG_UPDATE <= 1'b1;
                        PLP_ID     <= sh_plp;
                        T2_ID      <= sh_t2;
                        BITRATE    <= sh_bitrate;
                        ENABLE     <= sh_ctrl[0];
                        PCR_INSERT <= sh_ctrl[1];
                        if (!FRAME_START) begin
                            TIMEOUT_FLAG <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PENDING <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_config_ctrl.sv
// Scoreboard bench: expected active sets are queued at commit time and checked on each CFG_UPDATE pulse.
module tb_spi_config_ctrl;

    logic        CLK;
    logic        RST;
    logic [7:0]  SPI_DATA;
    logic [7:0]  SPI_ADDRESS;
    logic        SPI_ENA;
    logic        FRAME_START;
    logic [7:0]  PLP_ID;
    logic [15:0] T2_ID;
    logic [31:0] BITRATE;
    logic        ENABLE, PCR_INSERT, CFG_UPDATE, PENDING, TIMEOUT_FLAG, BAD_ADDR;

    // Second instance with a short timeout and no frame pulses.
    logic        to_ena;
    logic        no_frame;
    logic [7:0]  to_plp;
    logic [15:0] to_t2;
    logic [31:0] to_br;
    logic        to_en, to_pcr, to_cfg, to_pend, to_tflag, to_bad;

    typedef struct packed {
        logic [7:0]  plp;
        logic [15:0] t2;
        logic [31:0] br;
        logic        en;
        logic        pcr;
        logic        tf;
        logic        ba;
    } exp_t;

    exp_t exp_q[$];
    int   to_q[$];
    int   total = 0;
    int   bad   = 0;
    int   to_cnt = 0;

    spi_config_ctrl dut (
        .CLK(CLK), .RST(RST), .SPI_DATA(SPI_DATA), .SPI_ADDRESS(SPI_ADDRESS),
        .SPI_ENA(SPI_ENA), .FRAME_START(FRAME_START), .PLP_ID(PLP_ID), .T2_ID(T2_ID),
        .BITRATE(BITRATE), .ENABLE(ENABLE), .PCR_INSERT(PCR_INSERT), .CFG_UPDATE(CFG_UPDATE),
        .PENDING(PENDING), .TIMEOUT_FLAG(TIMEOUT_FLAG), .BAD_ADDR(BAD_ADDR)
    );

    spi_config_ctrl #(.APPLY_TIMEOUT(16'd3)) dut_to (
        .CLK(CLK), .RST(RST), .SPI_DATA(SPI_DATA), .SPI_ADDRESS(SPI_ADDRESS),
        .SPI_ENA(to_ena), .FRAME_START(no_frame), .PLP_ID(to_plp), .T2_ID(to_t2),
        .BITRATE(to_br), .ENABLE(to_en), .PCR_INSERT(to_pcr), .CFG_UPDATE(to_cfg),
        .PENDING(to_pend), .TIMEOUT_FLAG(to_tflag), .BAD_ADDR(to_bad)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        SPI_ADDRESS = a;
        SPI_DATA    = d;
        SPI_ENA     = 1'b1;
        tick();
        SPI_ENA     = 1'b0;
    endtask

    task automatic commit_exp(input exp_t e);
        exp_q.push_back(e);
        wr(8'h0F, 8'hA5);
    endtask

    task automatic frame();
        FRAME_START = 1'b1;
        tick();
        FRAME_START = 1'b0;
    endtask

    task automatic to_commit(input int exp_cycles);
        to_q.push_back(exp_cycles);
        SPI_ADDRESS = 8'h0F;
        SPI_DATA    = 8'h00;
        to_ena      = 1'b1;
        tick();
        to_ena      = 1'b0;
    endtask

    // Monitor for the main instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (CFG_UPDATE) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cfg_update", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("apply_outputs",
                        64'({PLP_ID, T2_ID, BITRATE, ENABLE, PCR_INSERT, TIMEOUT_FLAG, BAD_ADDR}),
                        64'(e));
                end
            end
        end
    end

    // Monitor for the timeout instance: counts PENDING cycles up to each forced apply.
    initial begin
        int e;
        forever begin
            @(negedge CLK);
            if (to_cfg) begin
                if (to_q.size() == 0) begin
                    chk("to_unexpected_cfg_update", 64'd1, 64'd0);
                end else begin
                    e = to_q.pop_front();
                    chk("to_pending_cycles", 64'(to_cnt), 64'(e));
                    chk("to_timeout_flag", 64'(to_tflag), 64'd1);
                end
                to_cnt = 0;
            end else if (to_pend) begin
                to_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; SPI_ENA = 1'b0; SPI_DATA = '0; SPI_ADDRESS = '0;
        FRAME_START = 1'b0; to_ena = 1'b0; no_frame = 1'b0;
        #1;
        chk("reset_outputs", 64'({PLP_ID, T2_ID, BITRATE, ENABLE, PCR_INSERT}), 64'd0);
        chk("reset_flags", 64'({CFG_UPDATE, PENDING, TIMEOUT_FLAG, BAD_ADDR}), 64'd0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Staged writes followed by a frame-aligned apply.
        wr(8'h01, 8'h2A);
        wr(8'h03, 8'h12);
        wr(8'h02, 8'h34);
        chk("shadow_only_plp", 64'(PLP_ID), 64'd0);
        commit_exp('{plp: 8'h2A, t2: 16'h1234, br: 32'h0, en: 1'b0, pcr: 1'b0, tf: 1'b0, ba: 1'b0});
        repeat (4) tick();
        chk("pending_high", 64'(PENDING), 64'd1);
        chk("before_frame_t2", 64'(T2_ID), 64'd0);
        chk("before_frame_cfg", 64'(CFG_UPDATE), 64'd0);
        frame();
        chk("apply_pulse", 64'(CFG_UPDATE), 64'd1);
        tick();
        chk("after_apply_flags", 64'({CFG_UPDATE, PENDING}), 64'd0);
        frame();
        tick();
        chk("idle_frame_no_effect", 64'(PLP_ID), 64'h2A);

        // Unmapped write flags BAD_ADDR, touches nothing, and the flag clears on commit.
        wr(8'h20, 8'h55);
        chk("bad_addr_set", 64'(BAD_ADDR), 64'd1);
        wr(8'h0C, 8'h55);
        chk("bad_addr_sticky", 64'(BAD_ADDR), 64'd1);
        commit_exp('{plp: 8'h2A, t2: 16'h1234, br: 32'h0, en: 1'b0, pcr: 1'b0, tf: 1'b0, ba: 1'b0});
        chk("bad_addr_cleared", 64'(BAD_ADDR), 64'd0);
        frame();
        tick();

        // Bitrate bytes LSB first and control bits.
        wr(8'h04, 8'h78);
        wr(8'h05, 8'h56);
        wr(8'h06, 8'h34);
        wr(8'h07, 8'h12);
        wr(8'h08, 8'hFF);
        commit_exp('{plp: 8'h2A, t2: 16'h1234, br: 32'h12345678, en: 1'b1, pcr: 1'b1, tf: 1'b0, ba: 1'b0});
        tick();
        frame();
        tick();

        // Second commit in PENDING is dropped; a write coinciding with the apply stays in shadow.
        wr(8'h01, 8'h11);
        commit_exp('{plp: 8'h11, t2: 16'h1234, br: 32'h12345678, en: 1'b1, pcr: 1'b1, tf: 1'b0, ba: 1'b0});
        tick();
        wr(8'h0F, 8'h00);
        tick();
        SPI_ADDRESS = 8'h01; SPI_DATA = 8'h99; SPI_ENA = 1'b1; FRAME_START = 1'b1;
        tick();
        SPI_ENA = 1'b0; FRAME_START = 1'b0;
        chk("coincident_write_plp", 64'(PLP_ID), 64'h11);
        // Commit sampled in APPLY goes straight back to PENDING.
        commit_exp('{plp: 8'h99, t2: 16'h1234, br: 32'h12345678, en: 1'b1, pcr: 1'b1, tf: 1'b0, ba: 1'b0});
        chk("commit_in_apply", 64'(PENDING), 64'd1);
        tick();
        frame();
        tick();

        // Reset while PENDING aborts the apply.
        wr(8'h02, 8'hAB);
        wr(8'h0F, 8'h00);
        tick();
        #3;
        RST = 1'b1;
        #1;
        chk("async_reset_outputs", 64'({PLP_ID, T2_ID, BITRATE, ENABLE, PCR_INSERT}), 64'd0);
        chk("async_reset_pending", 64'({PENDING, CFG_UPDATE}), 64'd0);
        tick();
        RST = 1'b0;
        frame();
        tick();
        chk("post_reset_outputs", 64'({PLP_ID, T2_ID, BITRATE, ENABLE, PCR_INSERT}), 64'd0);
        chk("post_reset_pending", 64'(PENDING), 64'd0);

        // Forced apply after APPLY_TIMEOUT+1 PENDING cycles.
        to_commit(4);
        repeat (6) tick();
        to_commit(4);
        chk("to_flag_cleared", 64'(to_tflag), 64'd0);
        repeat (6) tick();

        chk("main_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("to_queue_drained", 64'(to_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
